// File: rtl/reg_file_bypass.sv
// reg_file_bypass: 2-read/1-write register file with pending-bit scoreboard and optional write forwarding
//   Build option: define RF_BYPASS_EN to forward a same-cycle write to matching read ports.
//   Ports:
//     clk, resetN               clock (rising edge) and async active-low reset
//     readAddr1/2               read port addresses
//     readData1/2               combinational read data
//     readBusy1/2               pending-reservation flag of the addressed register
//     writeEn/Addr/Data         write port, sampled at clk rising edge
//     reserveEn/Addr            marks a register pending, sampled at clk rising edge
//   ZERO_REG=1 hard-wires register 0 to zero (never written, reserved or forwarded).
module reg_file_bypass #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              readBusy1,
  output logic              readBusy2,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              reserveEn,
  input  logic [ADDR_W-1:0] reserveAddr
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              wr_ok, rsv_ok;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];
  // Accesses to a hard-wired zero register are dropped entirely.
  assign wr_ok  = writeEn   && !(ZERO_REG != 0 && writeAddr   == '0);
  assign rsv_ok = reserveEn && !(ZERO_REG != 0 && reserveAddr == '0);
  // Reservation is applied after the write clear so a same-edge pair leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[writeAddr] = 1'b0;
    if (rsv_ok) pend_d[reserveAddr] = 1'b1;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok) regs_q[writeAddr] <= writeData;
      pend_q <= pend_d;
    end
  end
  assign ra[0] = readAddr1;
  assign ra[1] = readAddr2;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero, fwd;
    assign zero = ZERO_REG != 0 && ra[p] == '0;
`ifdef RF_BYPASS_EN
    assign fwd = wr_ok && writeAddr == ra[p];
`else
    assign fwd = 1'b0;
`endif
    // Outputs are forced to zero while reset is held, which also blocks forwarding.
    assign rd[p] = (!resetN || zero) ? '0 : fwd ? writeData : regs_q[ra[p]];
    assign rb[p] = (!resetN || zero || fwd) ? 1'b0 : pend_q[ra[p]];
  end
  assign readData1 = rd[0];
  assign readData2 = rd[1];
  assign readBusy1 = rb[0];
  assign readBusy2 = rb[1];
endmodule
